// File: rtl/montpro_param.sv
// Radix-2 Montgomery multiplier: r = a*b*2^-WID mod n.
// One bit of a per cycle, then a single conditional subtraction.
module montpro_param #(
  parameter int WID = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  input  logic [WID-1:0] n,
  input  logic           start,
  output logic [WID-1:0] r,
  output logic           done,
  output logic           busy,
  output logic           err
);

  localparam int CW = (WID > 1) ? $clog2(WID) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t         state;
  logic [WID-1:0] a_reg;
  logic [WID-1:0] b_reg;
  logic [WID-1:0] n_reg;
  logic [WID:0]   s;
  logic [CW-1:0]  cnt;

  logic [WID+1:0] t_add;
  logic [WID+1:0] t_red;
  logic [WID:0]   s_next;
  logic           s_ge_n;
  logic [WID-1:0] s_sub;

  // One Montgomery step on WID+2 bits plus the final reduction terms
  always_comb begin
    t_add  = {1'b0, s};
    if (a_reg[cnt])
      t_add = t_add + {2'b00, b_reg};
    t_red  = t_add;
    if (t_add[0])
      t_red = t_add + {2'b00, n_reg};
    s_next = (WID+1)'(t_red >> 1);
    s_ge_n = (s >= {1'b0, n_reg});
    s_sub  = s[WID-1:0] - n_reg;
  end

  // Control FSM with registered outputs; reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      n_reg <= '0;
      s     <= '0;
      cnt   <= '0;
      r     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            n_reg <= n;
            s     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= n[0] ? CALC : FIX;
          end
        end
        CALC: begin
          s <= s_next;
          if (cnt == CW'(WID-1)) begin
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (n_reg[0]) begin
            r   <= s_ge_n ? s_sub : s[WID-1:0];
            err <= 1'b0;
          end else begin
            r   <= '0;
            err <= 1'b1;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
